mem_stage: RTL and testbench

Memory stage of the pipelined processor. Sits directly downstream of the ALU stage and upstream of the write-back stage. Owns the data RAM, the stack pointer (push/pop), the output-port register and the MEM/WB pipeline register. Consumes ALU results plus control bits and produces one registered write-back record per cycle.

---
 rtl/mem_stage.sv | 75 +++++++
 tb/tb_mem_stage.sv | 103 ++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: data RAM, stack pointer, output port and MEM/WB register of the pipeline
//   clk, reset (sync, active-high), stall (hold all state)
//   alu_result/store_data/in_port_data: address or result, store/push/out data, input port value
//   mem_read_in/mem_write_in/push_in/pop_in: memory ops (push > pop > write > read)
//   in_port_in/out_port_in/wb_in/dest_in: port ops and write-back control
//   wb_en_out/wb_data_out/dest_out: registered write-back record
//   out_port: output-port register, sp_out: stack pointer, stack_fault: sticky over/underflow
module mem_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic [DATA_WIDTH-1:0]     store_data,
  input  logic [DATA_WIDTH-1:0]     in_port_data,
  input  logic                      mem_read_in,
  input  logic                      mem_write_in,
  input  logic                      push_in,
  input  logic                      pop_in,
  input  logic                      in_port_in,
  input  logic                      out_port_in,
  input  logic                      wb_in,
  input  logic [REG_ADDR_WIDTH-1:0] dest_in,
  output logic                      wb_en_out,
  output logic [DATA_WIDTH-1:0]     wb_data_out,
  output logic [REG_ADDR_WIDTH-1:0] dest_out,
  output logic [DATA_WIDTH-1:0]     out_port,
  output logic [ADDR_WIDTH-1:0]     sp_out,
  output logic                      stack_fault
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [ADDR_WIDTH-1:0] sp, addr, sp_inc, sp_next, waddr;
  logic [DATA_WIDTH-1:0] rd, wb_data;
  logic do_push, do_pop, do_st, do_ld, push_fault, pop_fault, we;
  assign sp_out = sp;
  always_comb begin
    addr = alu_result[ADDR_WIDTH-1:0];
    sp_inc = sp + 1'b1;
    do_push = push_in;
    do_pop = pop_in && !push_in;
    do_st = mem_write_in && !push_in && !pop_in;
    do_ld = mem_read_in && !push_in && !pop_in && !mem_write_in;
    push_fault = do_push && sp == '0;
    pop_fault = do_pop && sp == '1;
    rd = ram[do_pop ? sp_inc : addr];
    wb_data = pop_fault ? '0 : (do_ld || do_pop) ? rd : in_port_in ? in_port_data : alu_result;
    sp_next = (push_fault || pop_fault) ? sp : do_push ? sp - 1'b1 : do_pop ? sp_inc : sp;
    we = !reset && !stall && (do_st || (do_push && !push_fault));
    waddr = do_push ? sp : addr;
  end
  // RAM is never cleared; reset only blocks a concurrent write
  always_ff @(posedge clk)
    if (we) ram[waddr] <= store_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '1;
      out_port <= '0;
      wb_en_out <= 1'b0;
      wb_data_out <= '0;
      dest_out <= '0;
      stack_fault <= 1'b0;
    end else if (!stall) begin
      sp <= sp_next;
      if (out_port_in) out_port <= store_data;
      wb_en_out <= wb_in && !pop_fault;
      wb_data_out <= wb_data;
      dest_out <= dest_in;
      if (push_fault || pop_fault) stack_fault <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage load/store, stack, ports, faults, stall and reset
module tb_mem_stage;
  logic clk = 0, reset, stall;
  logic [15:0] alu_result, store_data, in_port_data;
  logic mem_read_in, mem_write_in, push_in, pop_in, in_port_in, out_port_in, wb_in;
  logic [2:0] dest_in;
  logic wb_en_out, stack_fault;
  logic [15:0] wb_data_out, out_port;
  logic [2:0] dest_out;
  logic [10:0] sp_out;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .alu_result(alu_result), .store_data(store_data),
    .in_port_data(in_port_data), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .push_in(push_in), .pop_in(pop_in), .in_port_in(in_port_in), .out_port_in(out_port_in),
    .wb_in(wb_in), .dest_in(dest_in), .wb_en_out(wb_en_out), .wb_data_out(wb_data_out),
    .dest_out(dest_out), .out_port(out_port), .sp_out(sp_out), .stack_fault(stack_fault)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    {reset, stall, mem_read_in, mem_write_in, push_in, pop_in, in_port_in, out_port_in, wb_in} = '0;
    alu_result = 0; store_data = 0; in_port_data = 0; dest_in = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic store(input logic [15:0] a, input logic [15:0] d);
    idle(); mem_write_in = 1; alu_result = a; store_data = d; step();
  endtask
  task automatic load(input logic [15:0] a, input logic [2:0] r);
    idle(); mem_read_in = 1; alu_result = a; wb_in = 1; dest_in = r; step();
  endtask
  task automatic push(input logic [15:0] d);
    idle(); push_in = 1; store_data = d; step();
  endtask
  task automatic pop(input logic [2:0] r);
    idle(); pop_in = 1; wb_in = 1; dest_in = r; step();
  endtask
  initial begin
    idle(); reset = 1; step(); step();
    chk("rst_sp", sp_out, 2047);
    chk("rst_out", out_port, 0);
    chk("rst_wben", wb_en_out, 0);
    chk("rst_wbdata", wb_data_out, 0);
    chk("rst_dest", dest_out, 0);
    chk("rst_fault", stack_fault, 0);
    store(16'h0805, 16'hBEEF);
    chk("st_wben", wb_en_out, 0);
    chk("st_wbdata", wb_data_out, 16'h0805);
    load(16'h0005, 3);
    chk("ld_data", wb_data_out, 16'hBEEF);
    chk("ld_dest", dest_out, 3);
    chk("ld_wben", wb_en_out, 1);
    push(16'h1111); chk("push1_sp", sp_out, 2046);
    push(16'h2222); chk("push2_sp", sp_out, 2045);
    pop(2); chk("pop1_sp", sp_out, 2046); chk("pop1_data", wb_data_out, 16'h2222);
    chk("pop1_wben", wb_en_out, 1);
    pop(2); chk("pop2_sp", sp_out, 2047); chk("pop2_data", wb_data_out, 16'h1111);
    pop(4);
    chk("popf_wben", wb_en_out, 0); chk("popf_data", wb_data_out, 0);
    chk("popf_sp", sp_out, 2047); chk("popf_fault", stack_fault, 1);
    idle(); out_port_in = 1; store_data = 16'h00A5; step();
    chk("outp_set", out_port, 16'h00A5);
    idle(); store_data = 16'hFFFF; step();
    chk("outp_hold", out_port, 16'h00A5);
    idle(); in_port_in = 1; in_port_data = 16'h1234; wb_in = 1; dest_in = 6; step();
    chk("inp_data", wb_data_out, 16'h1234);
    chk("fault_sticky", stack_fault, 1);
    store(16'h0007, 16'h0707);
    idle(); push_in = 1; mem_write_in = 1; alu_result = 16'h0007; store_data = 16'h7777; step();
    chk("prio_sp", sp_out, 2046);
    load(16'h0007, 1); chk("prio_nowrite", wb_data_out, 16'h0707);
    pop(1); chk("prio_pushed", wb_data_out, 16'h7777); chk("prio_sp2", sp_out, 2047);
    idle(); stall = 1; mem_write_in = 1; push_in = 1; out_port_in = 1; wb_in = 1;
    alu_result = 16'h0005; store_data = 16'hDEAD; dest_in = 5; step();
    chk("stall_sp", sp_out, 2047); chk("stall_data", wb_data_out, 16'h7777);
    chk("stall_dest", dest_out, 1); chk("stall_out", out_port, 16'h00A5);
    load(16'h0005, 0); chk("stall_ram", wb_data_out, 16'hBEEF);
    idle(); out_port_in = 1; store_data = 16'h0055; step();
    idle(); reset = 1; stall = 1; mem_write_in = 1; alu_result = 16'h0005; store_data = 16'h1111;
    wb_in = 1; dest_in = 7; step();
    chk("rs_sp", sp_out, 2047); chk("rs_out", out_port, 0); chk("rs_wben", wb_en_out, 0);
    chk("rs_data", wb_data_out, 0); chk("rs_fault", stack_fault, 0);
    load(16'h0005, 2); chk("rs_ram", wb_data_out, 16'hBEEF);
    store(16'h0000, 16'h5A5A);
    for (int i = 0; i < 2047; i++) push(16'(i));
    chk("full_sp", sp_out, 0); chk("full_nofault", stack_fault, 0);
    push(16'hFFFF);
    chk("pushf_sp", sp_out, 0); chk("pushf_fault", stack_fault, 1);
    load(16'h0000, 3); chk("pushf_ram0", wb_data_out, 16'h5A5A);
    pop(3); chk("pop_top", wb_data_out, 16'd2046); chk("pop_top_sp", sp_out, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
